// File: rtl/spi_ram_ctrl_burst.sv
// Command decoder between the SPI slave rx path and the shift-out tx path.
// It handles a single-port RAM with address load, write, read, burst auto-increment and a whole-memory FILL.
module spi_ram_ctrl_burst #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AUTO_INC   = 1,
    localparam int PAY_W     = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PAY_W+2:0]      din,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  tx_valid,
    output logic                  busy,
    output logic                  err
);
    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

    localparam logic [2:0] OP_SET_WADDR = 3'b000;
    localparam logic [2:0] OP_WRITE     = 3'b001;
    localparam logic [2:0] OP_SET_RADDR = 3'b010;
    localparam logic [2:0] OP_READ      = 3'b011;
    localparam logic [2:0] OP_FILL      = 3'b100;

    typedef enum logic {ST_IDLE, ST_FILL} state_t;

    // Handshake: a command is taken on a rising edge with rx_valid && rx_ready;
    // rx_valid while not ready is dropped, nothing is queued.
    state_t                  state;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [DATA_WIDTH-1:0]   fill_val;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic [2:0]              op;
    logic [ADDR_WIDTH-1:0]   pay_addr;
    logic [DATA_WIDTH-1:0]   pay_data;
    logic                    accept;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    unused_pay;

    assign op         = din[PAY_W+2 -: 3];
    assign pay_addr   = din[ADDR_WIDTH-1:0];
    assign pay_data   = din[DATA_WIDTH-1:0];
    assign unused_pay = ^din;
    assign rx_ready   = (state == ST_IDLE);
    assign busy       = (state == ST_FILL);
    assign accept     = rx_valid && rx_ready;

    // FILL and WRITE share the one write port; they never overlap because
    // commands are refused while filling. Reset blocks the write on its edge.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = w_addr;
        mem_wdata = pay_data;
        if (state == ST_FILL) begin
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = fill_val;
        end else if (accept && op == OP_WRITE) begin
            mem_we = 1'b1;
        end
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            w_addr   <= '0;
            r_addr   <= '0;
            cnt      <= '0;
            fill_val <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        case (op)
                            OP_SET_WADDR: w_addr <= pay_addr;
                            OP_WRITE: begin
                                if (AUTO_INC != 0) begin
                                    w_addr <= w_addr + 1'b1;
                                end
                            end
                            OP_SET_RADDR: r_addr <= pay_addr;
                            OP_READ: begin
                                dout     <= mem[r_addr];
                                tx_valid <= 1'b1;
                                if (AUTO_INC != 0) begin
                                    r_addr <= r_addr + 1'b1;
                                end
                            end
                            OP_FILL: begin
                                fill_val <= pay_data;
                                cnt      <= '0;
                                state    <= ST_FILL;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                ST_FILL: begin
                    if (&cnt) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_ram_ctrl_burst.sv
// Scoreboard bench for spi_ram_ctrl_burst: a default instance (8/8, auto-inc)
// and a narrow-address, wide-data, static-address instance (4/16, no auto-inc).
module tb_spi_ram_ctrl_burst;
    localparam logic [2:0] OP_SW = 3'b000;
    localparam logic [2:0] OP_WR = 3'b001;
    localparam logic [2:0] OP_SR = 3'b010;
    localparam logic [2:0] OP_RD = 3'b011;
    localparam logic [2:0] OP_FL = 3'b100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] din;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  dout;
    logic        tx_valid;
    logic        busy;
    logic        err;
    logic [18:0] din2;
    logic        rx_valid2;
    logic        rx_ready2;
    logic [15:0] dout2;
    logic        tx_valid2;
    logic        busy2;
    logic        err2;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // {expected cycle of tx_valid, expected dout}
    logic [47:0] exp_q[$];
    logic [47:0] exp2_q[$];
    int          err_q[$];
    logic [47:0] e1;
    logic [47:0] e2;

    spi_ram_ctrl_burst dut (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .dout(dout), .tx_valid(tx_valid), .busy(busy), .err(err)
    );

    spi_ram_ctrl_burst #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .AUTO_INC(0)) dut2 (
        .clk(clk), .rst(rst), .din(din2), .rx_valid(rx_valid2), .rx_ready(rx_ready2),
        .dout(dout2), .tx_valid(tx_valid2), .busy(busy2), .err(err2)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic cmd(input bit sel, input logic [2:0] op, input logic [15:0] pay);
        if (sel) begin
            din2      = {op, pay};
            rx_valid2 = 1'b1;
        end else begin
            din      = {op, pay[7:0]};
            rx_valid = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_valid  = 1'b0;
        rx_valid2 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input bit sel, input logic [15:0] exp);
        if (sel) exp2_q.push_back({32'(cyc + 1), exp});
        else     exp_q.push_back({32'(cyc + 1), exp});
        cmd(sel, OP_RD, 16'h0000);
    endtask

    task automatic bad(input logic [2:0] op, input logic [15:0] pay);
        err_q.push_back(cyc + 1);
        cmd(1'b0, op, pay);
    endtask

    task automatic fill_wait(input bit sel, input logic [15:0] pay, input int exp_cycles, input bit rogue);
        int n = 0;
        int ready_bad = 0;
        cmd(sel, OP_FL, pay);
        rx_valid  = 1'b0;
        rx_valid2 = 1'b0;
        while ((sel ? busy2 : busy) && n < 2000) begin
            n++;
            if ((sel ? rx_ready2 : rx_ready) !== 1'b0) ready_bad++;
            if (rogue && n == 200) begin
                din      = {OP_WR, 8'h99};
                rx_valid = 1'b1;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        chk("fill busy cycles", 32'(n), 32'(exp_cycles));
        chk("rx_ready low while busy", 32'(ready_bad), 32'd0);
        chk("rx_ready after fill", {31'd0, sel ? rx_ready2 : rx_ready}, 32'd1);
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0][47:16] < 32'(cyc)) begin
                e1 = exp_q.pop_front();
                chk("tx_valid missing", 32'(cyc), e1[47:16]);
            end
            if (tx_valid) begin
                if (exp_q.size() == 0) begin
                    chk("tx_valid spurious", {31'd0, tx_valid}, 32'd0);
                end else begin
                    e1 = exp_q.pop_front();
                    chk("tx_valid cycle", 32'(cyc), e1[47:16]);
                    chk("dout", {24'd0, dout}, {24'd0, e1[7:0]});
                end
            end
            if (err_q.size() > 0 && err_q[0] < cyc) begin
                chk("err missing", 32'(cyc), 32'(err_q.pop_front()));
            end
            if (err) begin
                if (err_q.size() == 0) chk("err spurious", {31'd0, err}, 32'd0);
                else chk("err cycle", 32'(cyc), 32'(err_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (exp2_q.size() > 0 && exp2_q[0][47:16] < 32'(cyc)) begin
                e2 = exp2_q.pop_front();
                chk("dut2 tx_valid missing", 32'(cyc), e2[47:16]);
            end
            if (tx_valid2) begin
                if (exp2_q.size() == 0) begin
                    chk("dut2 tx_valid spurious", {31'd0, tx_valid2}, 32'd0);
                end else begin
                    e2 = exp2_q.pop_front();
                    chk("dut2 tx_valid cycle", 32'(cyc), e2[47:16]);
                    chk("dut2 dout", {16'd0, dout2}, {16'd0, e2[15:0]});
                end
            end
            if (err2) chk("dut2 err spurious", {31'd0, err2}, 32'd0);
        end
    end

    initial begin
        din       = '0;
        rx_valid  = 1'b0;
        din2      = '0;
        rx_valid2 = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset dout", {24'd0, dout}, 32'd0);
        chk("reset tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("reset dut2 dout", {16'd0, dout2}, 32'd0);
        chk("reset dut2 rx_ready", {31'd0, rx_ready2}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // basic write then read
        fill_wait(1'b0, 16'h00, 256, 1'b0);
        cmd(1'b0, OP_SW, 16'h10);
        cmd(1'b0, OP_WR, 16'hA5);
        cmd(1'b0, OP_SR, 16'h10);
        rd(1'b0, 16'hA5);
        idle(2);

        // burst with wrap; the trailing write/read land at address 0x01
        cmd(1'b0, OP_SW, 16'hFE);
        cmd(1'b0, OP_WR, 16'h11);
        cmd(1'b0, OP_WR, 16'h22);
        cmd(1'b0, OP_WR, 16'h33);
        cmd(1'b0, OP_SR, 16'hFE);
        rd(1'b0, 16'h11);
        rd(1'b0, 16'h22);
        rd(1'b0, 16'h33);
        cmd(1'b0, OP_WR, 16'h44);
        rd(1'b0, 16'h44);
        idle(2);

        // full fill with a write presented while busy (w_addr=0x10)
        cmd(1'b0, OP_SW, 16'h10);
        idle(1);
        fill_wait(1'b0, 16'h5A, 256, 1'b1);
        cmd(1'b0, OP_SR, 16'h00);
        rd(1'b0, 16'h5A);
        cmd(1'b0, OP_SR, 16'h7F);
        rd(1'b0, 16'h5A);
        cmd(1'b0, OP_SR, 16'hFF);
        rd(1'b0, 16'h5A);
        cmd(1'b0, OP_SR, 16'h10);
        rd(1'b0, 16'h5A);
        idle(2);

        // illegal opcodes leave addresses and dout alone
        cmd(1'b0, OP_SW, 16'h20);
        cmd(1'b0, OP_WR, 16'h6B);
        cmd(1'b0, OP_WR, 16'h7C);
        cmd(1'b0, OP_SR, 16'h20);
        rd(1'b0, 16'h6B);
        bad(3'b110, 16'h3C);
        idle(1);
        chk("dout held after illegal", {24'd0, dout}, 32'h6B);
        rd(1'b0, 16'h7C);
        bad(3'b101, 16'h00);
        bad(3'b111, 16'hFF);
        cmd(1'b0, OP_WR, 16'h8D);
        cmd(1'b0, OP_SR, 16'h22);
        rd(1'b0, 16'h8D);
        idle(2);

        // reset aborts a fill after 99 words written
        fill_wait(1'b0, 16'h00, 256, 1'b0);
        cmd(1'b0, OP_FL, 16'hC3);
        idle(99);
        rst = 1'b1;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("abort dout", {24'd0, dout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmd(1'b0, OP_SR, 16'h00);
        rd(1'b0, 16'hC3);
        cmd(1'b0, OP_SR, 16'h62);
        rd(1'b0, 16'hC3);
        cmd(1'b0, OP_SR, 16'h63);
        rd(1'b0, 16'h00);
        cmd(1'b0, OP_SR, 16'hFF);
        rd(1'b0, 16'h00);
        idle(2);

        // narrow address, wide data, static addresses
        fill_wait(1'b1, 16'h0000, 16, 1'b0);
        cmd(1'b1, OP_SW, 16'h0013);
        cmd(1'b1, OP_WR, 16'hBEEF);
        cmd(1'b1, OP_WR, 16'hBEEF);
        cmd(1'b1, OP_SR, 16'h0003);
        rd(1'b1, 16'hBEEF);
        rd(1'b1, 16'hBEEF);
        cmd(1'b1, OP_SR, 16'h0004);
        rd(1'b1, 16'h0000);
        idle(4);

        chk("dout queue drained", 32'(exp_q.size()), 32'd0);
        chk("dut2 dout queue drained", 32'(exp2_q.size()), 32'd0);
        chk("err queue drained", 32'(err_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
